// File: rtl/xt_bus_pkg.sv
// XT_BUS local-bus slave view and the address-match helpers shared by bus peripherals.
package xt_bus_pkg;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] wdata;
    } lb_slave_t;

    function automatic logic MatchWLB(input lb_slave_t lb, input logic [15:0] addr);
        return lb.wr && (lb.addr == addr);
    endfunction

    function automatic logic MatchRLB(input lb_slave_t lb, input logic [15:0] addr);
        return lb.rd && (lb.addr == addr);
    endfunction

endpackage

// File: rtl/led_seg_lbus.sv
// Local-bus output peripheral: CPU-written LED register with per-bit blink and a
// time-multiplexed 4-digit common-anode hex display, all registers readable back.
module led_seg_lbus
    import xt_bus_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic        lb_clk,
    input  logic        lb_rst,
    input  lb_slave_t   xt_lb,
    output logic [15:0] rdata,
    output logic [7:0]  led_n,
    output logic [7:0]  seg_n,
    output logic [3:0]  dig_n
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    localparam logic [15:0] ADDR_LED   = 16'h0000;
    localparam logic [15:0] ADDR_SEG   = 16'h0002;
    localparam logic [15:0] ADDR_CTRL  = 16'h0004;
    localparam logic [15:0] ADDR_BLINK = 16'h0006;

    logic [7:0]    led_r;
    logic [15:0]   seg_data_r;
    logic [3:0]    seg_en_r;
    logic [3:0]    seg_dp_r;
    logic [7:0]    blink_r;
    logic [PW-1:0] pre_r;
    logic [1:0]    dig_idx_r;
    logic [BW-1:0] blink_cnt_r;
    logic          phase_r;
    logic [7:0]    led_n_r;
    logic [7:0]    seg_n_r;
    logic [3:0]    dig_n_r;

    logic          scan_tick_s;
    logic [3:0]    nibble_s;
    logic          dig_on_s;
    logic          dp_s;
    logic [7:0]    led_next_s;
    logic [7:0]    seg_next_s;
    logic [3:0]    dig_next_s;
    logic [15:0]   rdata_s;

    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    assign scan_tick_s = (pre_r == PRE_LAST);

    // CPU-visible registers; unused write bits are simply dropped.
    always_ff @(posedge lb_clk) begin
        if (lb_rst) begin
            led_r      <= 8'h00;
            seg_data_r <= 16'h0000;
            seg_en_r   <= 4'h0;
            seg_dp_r   <= 4'h0;
            blink_r    <= 8'h00;
        end else begin
            if (MatchWLB(xt_lb, ADDR_LED)) begin
                led_r <= xt_lb.wdata[7:0];
            end
            if (MatchWLB(xt_lb, ADDR_SEG)) begin
                seg_data_r <= xt_lb.wdata[15:0];
            end
            if (MatchWLB(xt_lb, ADDR_CTRL)) begin
                seg_en_r <= xt_lb.wdata[3:0];
                seg_dp_r <= xt_lb.wdata[7:4];
            end
            if (MatchWLB(xt_lb, ADDR_BLINK)) begin
                blink_r <= xt_lb.wdata[7:0];
            end
        end
    end

    // Scan prescaler, digit index and blink phase; everything advances on scan ticks.
    always_ff @(posedge lb_clk) begin
        if (lb_rst) begin
            pre_r       <= '0;
            dig_idx_r   <= 2'd0;
            blink_cnt_r <= '0;
            phase_r     <= 1'b0;
        end else if (scan_tick_s) begin
            pre_r     <= '0;
            dig_idx_r <= dig_idx_r + 2'd1;
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r <= '0;
                phase_r     <= ~phase_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BW'(1'b1);
            end
        end else begin
            pre_r <= pre_r + PW'(1'b1);
        end
    end

    // Next pin values from the current digit slot and blink phase.
    always_comb begin
        nibble_s   = 4'h0;
        dig_on_s   = seg_en_r[dig_idx_r];
        dp_s       = seg_dp_r[dig_idx_r];
        seg_next_s = 8'hFF;
        dig_next_s = 4'hF;
        case (dig_idx_r)
            2'd0:    nibble_s = seg_data_r[3:0];
            2'd1:    nibble_s = seg_data_r[7:4];
            2'd2:    nibble_s = seg_data_r[11:8];
            2'd3:    nibble_s = seg_data_r[15:12];
            default: nibble_s = 4'h0;
        endcase
        // A disabled digit still consumes its slot, so the others keep their duty cycle.
        if (dig_on_s) begin
            dig_next_s = ~(4'b0001 << dig_idx_r);
            seg_next_s = ~{dp_s, hex7seg(nibble_s)};
        end else begin
            dig_next_s = 4'hF;
            seg_next_s = 8'hFF;
        end
        led_next_s = ~(led_r & ~(blink_r & {8{phase_r}}));
    end

    // Output flops keep the pins glitch-free.
    always_ff @(posedge lb_clk) begin
        if (lb_rst) begin
            led_n_r <= 8'hFF;
            seg_n_r <= 8'hFF;
            dig_n_r <= 4'hF;
        end else begin
            led_n_r <= led_next_s;
            seg_n_r <= seg_next_s;
            dig_n_r <= dig_next_s;
        end
    end

    // Read mux returns register contents before any same-cycle write lands.
    always_comb begin
        rdata_s = 16'h0000;
        if (MatchRLB(xt_lb, ADDR_LED)) begin
            rdata_s = {8'h00, led_r};
        end else if (MatchRLB(xt_lb, ADDR_SEG)) begin
            rdata_s = seg_data_r;
        end else if (MatchRLB(xt_lb, ADDR_CTRL)) begin
            rdata_s = {8'h00, seg_dp_r, seg_en_r};
        end else if (MatchRLB(xt_lb, ADDR_BLINK)) begin
            rdata_s = {8'h00, blink_r};
        end else begin
            rdata_s = 16'h0000;
        end
    end

    assign rdata = rdata_s;
    assign led_n = led_n_r;
    assign seg_n = seg_n_r;
    assign dig_n = dig_n_r;

endmodule

// File: tb/tb_led_seg_lbus.sv
// Directed bench for led_seg_lbus with SCAN_DIV=4, BLINK_TICKS=2.
module tb_led_seg_lbus;
    import xt_bus_pkg::*;

    logic        lb_clk = 1'b0;
    logic        lb_rst;
    lb_slave_t   xt_lb;
    logic [15:0] rdata;
    logic [7:0]  led_n;
    logic [7:0]  seg_n;
    logic [3:0]  dig_n;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        logic        chk_led;
        logic [7:0]  exp_led;
    } vec_t;

    vec_t vecs[$];

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0]  dig_code [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0]  seg_1234 [4] = '{8'h19, 8'hB0, 8'hA4, 8'hF9};
    logic [15:0] pats     [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};

    led_seg_lbus #(.SCAN_DIV(4), .BLINK_TICKS(2)) dut (
        .lb_clk (lb_clk),
        .lb_rst (lb_rst),
        .xt_lb  (xt_lb),
        .rdata  (rdata),
        .led_n  (led_n),
        .seg_n  (seg_n),
        .dig_n  (dig_n)
    );

    always #5 lb_clk = ~lb_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge lb_clk);
        #1;
    endtask

    task automatic bus(input logic wr, input logic rd, input logic [15:0] addr, input logic [15:0] wd);
        xt_lb.wr    = wr;
        xt_lb.rd    = rd;
        xt_lb.addr  = addr;
        xt_lb.wdata = wd;
    endtask

    task automatic wr_reg(input logic [15:0] addr, input logic [15:0] wd);
        bus(1'b1, 1'b0, addr, wd);
        step();
        bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic rd_chk(input string name, input logic [15:0] addr, input logic [15:0] exp);
        bus(1'b0, 1'b1, addr, 16'h0000);
        #1;
        chk(name, rdata, exp);
        bus(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic wait_dig(input logic [3:0] val);
        int n = 0;
        while (dig_n !== val && n < 64) begin
            step();
            n++;
        end
        if (dig_n !== val) begin
            total++;
            bad++;
            $display("FAIL wait_dig: got %h expected %h within 64 cycles", dig_n, val);
        end
    endtask

    task automatic add(input logic wr, input logic rd, input logic [15:0] addr, input logic [15:0] wd,
                       input logic [15:0] exp_rd, input logic chk_led, input logic [7:0] exp_led);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.wd = wd;
        v.exp_rd = exp_rd; v.chk_led = chk_led; v.exp_led = exp_led;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] v0;
        logic [7:0] vb;
        logic [7:0] other;
        logic [3:0] nib;
        int         k;
        int         n;

        lb_rst = 1'b1;
        bus(1'b0, 1'b0, 16'h0000, 16'h0000);
        step();
        step();
        lb_rst = 1'b0;
        chk("reset led_n", led_n, 16'h00FF);
        chk("reset seg_n", seg_n, 16'h00FF);
        chk("reset dig_n", dig_n, 16'h000F);

        // {wr, rd, addr, wdata, expected rdata, check led, expected led_n}
        add(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 8'hFF);
        add(1'b0, 1'b1, 16'h0002, 16'h0000, 16'h0000, 1'b1, 8'hFF);
        add(1'b0, 1'b1, 16'h0004, 16'h0000, 16'h0000, 1'b1, 8'hFF);
        add(1'b0, 1'b1, 16'h0006, 16'h0000, 16'h0000, 1'b1, 8'hFF);
        add(1'b0, 1'b1, 16'h0008, 16'h0000, 16'h0000, 1'b1, 8'hFF);
        add(1'b1, 1'b0, 16'h0000, 16'hFFA5, 16'h0000, 1'b1, 8'hFF);
        add(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 8'hFF);
        add(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h00A5, 1'b1, 8'h5A);
        add(1'b1, 1'b1, 16'h0000, 16'h0011, 16'h00A5, 1'b1, 8'h5A);
        add(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0011, 1'b1, 8'h5A);
        add(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 8'hEE);
        add(1'b1, 1'b0, 16'h0008, 16'hBEEF, 16'h0000, 1'b1, 8'hEE);
        add(1'b0, 1'b1, 16'h0008, 16'h0000, 16'h0000, 1'b1, 8'hEE);
        add(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0011, 1'b1, 8'hEE);
        add(1'b1, 1'b0, 16'h0002, 16'h1234, 16'h0000, 1'b0, 8'h00);
        add(1'b1, 1'b0, 16'h0004, 16'hFF1F, 16'h0000, 1'b0, 8'h00);
        add(1'b0, 1'b1, 16'h0002, 16'h0000, 16'h1234, 1'b0, 8'h00);
        add(1'b0, 1'b1, 16'h0004, 16'h0000, 16'h001F, 1'b0, 8'h00);
        add(1'b1, 1'b0, 16'h0006, 16'h12C3, 16'h0000, 1'b1, 8'hEE);
        add(1'b0, 1'b1, 16'h0006, 16'h0000, 16'h00C3, 1'b1, 8'hEE);
        add(1'b1, 1'b0, 16'h0006, 16'h0000, 16'h0000, 1'b0, 8'h00);
        add(1'b0, 1'b1, 16'h0006, 16'h0000, 16'h0000, 1'b0, 8'h00);
        add(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 8'hEE);

        foreach (vecs[i]) begin
            bus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wd);
            #1;
            chk($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rd);
            if (vecs[i].chk_led) begin
                chk($sformatf("vec%0d led_n", i), led_n, {8'h00, vecs[i].exp_led});
            end
            step();
        end
        bus(1'b0, 1'b0, 16'h0000, 16'h0000);

        // Full scan of 0x1234 with all digits on and dp on digit 0.
        wait_dig(4'h7);
        wait_dig(4'hE);
        for (int c = 0; c < 20; c++) begin
            k = (c / 4) % 4;
            chk($sformatf("scan c%0d dig_n", c), dig_n, dig_code[k]);
            chk($sformatf("scan c%0d seg_n", c), seg_n, seg_1234[k]);
            step();
        end

        // Digits 1 and 3 disabled: dark slots keep their length.
        wr_reg(16'h0004, 16'h0005);
        wait_dig(4'hB);
        wait_dig(4'hE);
        for (int c = 0; c < 16; c++) begin
            k = (c / 4) % 4;
            if (k == 0) begin
                chk($sformatf("mask c%0d dig_n", c), dig_n, 16'h000E);
                chk($sformatf("mask c%0d seg_n", c), seg_n, 16'h0099);
            end else if (k == 2) begin
                chk($sformatf("mask c%0d dig_n", c), dig_n, 16'h000B);
                chk($sformatf("mask c%0d seg_n", c), seg_n, 16'h00A4);
            end else begin
                chk($sformatf("mask c%0d dig_n", c), dig_n, 16'h000F);
                chk($sformatf("mask c%0d seg_n", c), seg_n, 16'h00FF);
            end
            step();
        end

        // Every hex glyph, one digit per slot, no decimal points.
        wr_reg(16'h0004, 16'h000F);
        foreach (pats[p]) begin
            wr_reg(16'h0002, pats[p]);
            wait_dig(4'h7);
            wait_dig(4'hE);
            for (int c = 0; c < 16; c++) begin
                k   = c / 4;
                nib = pats[p][4*k +: 4];
                chk($sformatf("hex %h c%0d dig_n", pats[p], c), dig_n, dig_code[k]);
                chk($sformatf("hex %h c%0d seg_n", pats[p], c), seg_n, {8'h00, ~{1'b0, hex_tab[nib]}});
                step();
            end
        end

        // Blink: low nibble toggles every 2 scan ticks = 8 cycles.
        wr_reg(16'h0000, 16'h00FF);
        wr_reg(16'h0006, 16'h000F);
        step();
        step();
        step();
        v0 = led_n;
        n  = 0;
        while (led_n === v0 && n < 40) begin
            step();
            n++;
        end
        vb = led_n;
        chk("blink level valid", {15'h0000, (vb == 8'h00 || vb == 8'h0F)}, 16'h0001);
        other = (vb == 8'h00) ? 8'h0F : 8'h00;
        for (int c = 0; c < 32; c++) begin
            chk($sformatf("blink c%0d led_n", c), led_n, ((c / 8) % 2 == 0) ? vb : other);
            step();
        end

        // Reset in the middle of the digit-2 slot.
        wait_dig(4'hB);
        lb_rst = 1'b1;
        step();
        lb_rst = 1'b0;
        chk("midscan rst led_n", led_n, 16'h00FF);
        chk("midscan rst seg_n", seg_n, 16'h00FF);
        chk("midscan rst dig_n", dig_n, 16'h000F);
        bus(1'b1, 1'b1, 16'h0004, 16'h000F);
        #1;
        chk("rst ctrl rd-while-wr", rdata, 16'h0000);
        step();
        bus(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("post rst n1 dig_n", dig_n, 16'h000F);
        for (int m = 2; m <= 13; m++) begin
            step();
            k = ((m - 1) / 4) % 4;
            chk($sformatf("post rst n%0d dig_n", m), dig_n, dig_code[k]);
            chk($sformatf("post rst n%0d seg_n", m), seg_n, 16'h00C0);
        end
        chk("post rst led_n", led_n, 16'h00FF);
        rd_chk("post rst LED", 16'h0000, 16'h0000);
        rd_chk("post rst SEG_DATA", 16'h0002, 16'h0000);
        rd_chk("post rst BLINK", 16'h0006, 16'h0000);
        rd_chk("post rst SEG_CTRL", 16'h0004, 16'h000F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_seg_lbus.md
Name: led_seg_lbus

Overview:
Write-side local-bus output peripheral. It is the output counterpart of the switch/key input block on the same XT_BUS local bus.
- Holds CPU-written LED and 7-segment registers.
- Drives 8 board LEDs with per-bit blink.
- Time-multiplexes a 4-digit common-anode hex display.
- All registers are readable back over the bus.

Parameters:
SCAN_DIV, 50000, lb_clk cycles per digit slot; legal range ≥2.
BLINK_TICKS, 250, scan ticks per blink-phase toggle; legal range ≥1.

Ports:
lb_clk  input  1  local-bus clock; sole clock.
lb_rst  input  1  synchronous, active-high reset.
xt_lb  input  lb_slave_t  local-bus slave view; decoded with XT_BUS helpers MatchWLB/MatchRLB; write data is xt_lb.wdata[15:0].
rdata  output  16  read data; combinational.
led_n  output  8  LED pins, active-low, registered.
seg_n  output  8  segment pins, active-low, registered; [6:0]=g..a, [7]=dp.
dig_n  output  4  digit select, active-low one-hot, registered.

Behaviour:
Register map (byte address, 16-bit access):
- 0x00 LED, [7:0] used.
- 0x02 SEG_DATA, [15:0]; digit k shows nibble [4k+3:4k].
- 0x04 SEG_CTRL: [3:0] digit enable, [7:4] decimal point per digit.
- 0x06 BLINK, [7:0] blink mask.
- Unused bits are written-ignored and read as 0.

Writes:
- When MatchWLB(xt_lb, addr) is true, the register updates at the next lb_clk edge.
- Writes to unmapped addresses are ignored.

Reads:
- rdata = register value when MatchRLB matches the register's address; 0 otherwise.
- A read and write to the same address in the same cycle returns the pre-write value.

Reset:
- All registers = 0; prescaler = 0; digit index = 0; blink counter = 0; blink phase = 0.
- led_n = 8'hFF, seg_n = 8'hFF, dig_n = 4'hF.
- Reset asserted mid-scan overrides everything; the scan restarts at digit 0 with a full SCAN_DIV slot.

Scan:
- Prescaler counts 0..SCAN_DIV-1; reaching terminal count is a scan tick.
- On a scan tick: prescaler → 0 and digit index increments, wrapping 3→0.
- Each digit slot is exactly SCAN_DIV cycles.

Display outputs (registered each cycle from current index i and registers; 1-cycle latency):
- Digit i enabled: dig_n = ~(1<<i); seg_n = ~{dp[i], hex7seg(nibble i)}.
- Digit i disabled: dig_n = 4'hF, seg_n = 8'hFF.
- Disabled digits keep their slot time; brightness of other digits is unchanged.
- hex7seg (g..a) for 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.

Blink:
- Blink counter counts scan ticks 0..BLINK_TICKS-1; at terminal count it → 0 and blink phase toggles.
- led_n = ~(LED & ~(BLINK & {8{phase}})), registered, 1-cycle latency.
- Blink-masked bits are lit in phase 0 and dark in phase 1.
- Writing BLINK does not reset the phase.

Timing:
- Register write to pin change is 2 cycles: 1 cycle to the register, 1 cycle to the output flop.

Test Plan:
1. Reset with SCAN_DIV=4, BLINK_TICKS=2 → led_n=FF, seg_n=FF, dig_n=F; read 0x00/0x02/0x04/0x06 → rdata=0; read 0x08 → 0.
2. Write 0xFFA5 to 0x00 → led_n=0x5A two cycles after the write cycle; read 0x00 → 0x00A5; read-while-write of 0x0011 returns 0x00A5 that cycle, 0x0011 next cycle.
3. SEG_DATA=0x1234, SEG_CTRL=0x001F, SCAN_DIV=4 → dig_n sequence E,D,B,7, each held exactly 4 cycles, wrapping to E.
   - Digit0: seg_n=0x19 (dp on, "4").
   - Digit1: seg_n=0xB0.
   - Digit2: seg_n=0xA4.
   - Digit3: seg_n=0xF9.
4. SEG_CTRL=0x0005 → digit-1 and digit-3 slots show dig_n=F, seg_n=FF; digits 0 and 2 are unchanged; slot length stays 4 cycles.
5. LED=0xFF, BLINK=0x0F, SCAN_DIV=4, BLINK_TICKS=2 → led_n alternates 0x00 / 0x0F, each phase lasting 8 cycles.
6. Assert lb_rst for 1 cycle during the digit-2 slot with registers nonzero → next cycle all outputs are at reset values and all registers read 0; after rewriting SEG_CTRL=0x000F, the scan starts at digit 0 with a full 4-cycle slot.
